// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: shares the 4-lane data-memory block RAM between the
// pipeline MEM stage (port A) and the debug/loader unit (port B).
// Each access is IDLE -> ISSUE -> (WAIT x READ_LAT for reads) -> DONE.
// Round-robin arbitration between A and B; A wins the first tie after reset.
// Optional feature macro: DMEM_BYTE_LANES_EN enables sub-word stores on
// port A (byte/half lane enables and replicated store data). Without it,
// every store is a full word.
//
// Handshake: a requester raises x_req with its command stable and holds it
// until x_done pulses for one cycle; dropping x_req earlier does not abort
// an access that was already granted.
module dmem_access_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  output logic              a_done,
  output logic              stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic [31:0]       b_rdata,
  output logic              b_done,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic       last_b;     // 1 when port B was the most recently granted port
  logic       sel_b;      // port owning the access in flight
  logic       cmd_we;     // access in flight is a write
  logic [1:0] wait_cnt;   // counts RAM read-latency cycles
  logic       gnt_b;
  logic [3:0] a_lanes;
  logic [31:0] a_wdat;
  logic       unused_bits;

  // Byte-offset bits of B are don't-care; size/offset of A only matter with sub-word stores.
  assign unused_bits = ^{a_size, a_addr[1:0], b_addr[1:0]};

  // The MEM stage waits until its own completion pulse arrives.
  assign stall = a_req & ~a_done;

  // Grant B when it is alone, or when both ask and A was served last.
  assign gnt_b = b_req & (~a_req | ~last_b);

  // Port A lane enables and store data alignment.
  always_comb begin
    a_lanes = 4'b1111;
    a_wdat  = a_wdata;
`ifdef DMEM_BYTE_LANES_EN
    case (a_size)
      2'b00: begin
        a_lanes = 4'b0001 << a_addr[1:0];
        a_wdat  = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        a_lanes = a_addr[1] ? 4'b1100 : 4'b0011;
        a_wdat  = {2{a_wdata[15:0]}};
      end
      default: begin
        a_lanes = 4'b1111;
        a_wdat  = a_wdata;
      end
    endcase
`endif
  end

  // Access sequencer: grant, one-cycle RAM issue, read-latency wait, done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      sel_b    <= 1'b0;
      cmd_we   <= 1'b0;
      wait_cnt <= 2'd0;
      mem_en   <= 1'b0;
      mem_we   <= 4'b0000;
      mem_addr <= '0;
      mem_din  <= 32'd0;
      a_rdata  <= 32'd0;
      b_rdata  <= 32'd0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 4'b0000;
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            sel_b  <= gnt_b;
            last_b <= gnt_b;
            mem_en <= 1'b1;
            state  <= ISSUE;
            if (gnt_b) begin
              cmd_we   <= b_we;
              mem_we   <= b_we ? 4'b1111 : 4'b0000;
              mem_addr <= b_addr[ADDR_W-1:2];
              mem_din  <= b_wdata;
            end else begin
              cmd_we   <= a_we;
              mem_we   <= a_we ? a_lanes : 4'b0000;
              mem_addr <= a_addr[ADDR_W-1:2];
              mem_din  <= a_wdat;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= 2'd0;
          if (cmd_we) begin
            state <= DONE;
            if (sel_b) b_done <= 1'b1;
            else       a_done <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'(READ_LAT - 1)) begin
            state <= DONE;
            if (sel_b) begin
              b_rdata <= mem_dout;
              b_done  <= 1'b1;
            end else begin
              a_rdata <= mem_dout;
              a_done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
